// File: rtl/id_decode_queue.sv
// IF->ID decoupling queue: buffers fetched words with pre-decoded branch class,
// delay-slot flag and EPC so decode receives a ready-to-use bundle (FWFT head).
module id_decode_queue #(
    parameter int PTR_W = 2,
    parameter int EXC_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_next_pc,
    input  logic [EXC_W-1:0] in_exc_code,
    input  logic [31:0]      in_exc_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_next_pc,
    output logic [31:0]      out_epc,
    output logic [31:0]      out_badvaddr,
    output logic [EXC_W-1:0] out_exc_code,
    output logic             out_is_branch,
    output logic             out_in_delay_slot,
    output logic [PTR_W:0]   count
);
    localparam int DEPTH = 1 << PTR_W;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]      instr;
        logic [31:0]      next_pc;
        logic [31:0]      epc;
        logic [31:0]      badvaddr;
        logic [EXC_W-1:0] exc_code;
        logic             is_branch;
        logic             in_ds;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_last_br;

    logic               w_push;
    logic               w_pop;
    logic               w_is_exc;
    logic               w_dec_branch;
    logic [5:0]         w_op;
    logic [4:0]         w_rt;
    logic [5:0]         w_func;
    entry_t             w_entry;
    entry_t             w_head;

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~clear;
    assign w_pop     = out_valid & out_ready & ~clear;

    assign w_op     = in_instr[31:26];
    assign w_rt     = in_instr[20:16];
    assign w_func   = in_instr[5:0];
    assign w_is_exc = (in_exc_code != '0);

    // Anything with an architectural delay slot: J/JAL, the four compare branches,
    // REGIMM BLTZ/BGEZ, and SPECIAL JR/JALR.
    always_comb begin
        w_dec_branch = 1'b0;
        case (w_op)
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: w_dec_branch = 1'b1;
            6'h01: w_dec_branch = (w_rt == 5'h00) || (w_rt == 5'h01);
            6'h00: w_dec_branch = (w_func == 6'h08) || (w_func == 6'h09);
            default: w_dec_branch = 1'b0;
        endcase
    end

    // A delay-slot instruction reports the EPC of its branch, one word back.
    always_comb begin
        w_entry.next_pc  = in_next_pc;
        w_entry.exc_code = in_exc_code;
        w_entry.in_ds    = r_last_br;
        if (w_is_exc) begin
            w_entry.instr     = 32'h0;
            w_entry.epc       = in_exc_addr;
            w_entry.badvaddr  = in_exc_addr;
            w_entry.is_branch = 1'b0;
        end else begin
            w_entry.instr     = in_instr;
            w_entry.epc       = r_last_br ? (in_next_pc - 32'd8) : (in_next_pc - 32'd4);
            w_entry.badvaddr  = 32'h0;
            w_entry.is_branch = w_dec_branch;
        end
    end

    // Storage is deliberately not reset; out_valid qualifies the head.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_last_br <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                r_last_br <= w_entry.is_branch;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head            = r_mem[r_rd_ptr];
    assign out_instr         = w_head.instr;
    assign out_next_pc       = w_head.next_pc;
    assign out_epc           = w_head.epc;
    assign out_badvaddr      = w_head.badvaddr;
    assign out_exc_code      = w_head.exc_code;
    assign out_is_branch     = w_head.is_branch;
    assign out_in_delay_slot = w_head.in_ds;
    assign count             = r_count;

endmodule

// File: tb/tb_id_decode_queue.sv
// Scoreboard bench for id_decode_queue: expected bundles are queued on push and
// compared against the FWFT head whenever a pop is driven.
module tb_id_decode_queue;
    localparam int PTR_W = 2;
    localparam int EXC_W = 5;
    localparam int DEPTH = 4;
    localparam logic [4:0] EC_ADEL = 5'd4;

    logic             clk, rst, clear, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_instr, in_next_pc, in_exc_addr;
    logic [EXC_W-1:0] in_exc_code, out_exc_code;
    logic [31:0]      out_instr, out_next_pc, out_epc, out_badvaddr;
    logic             out_is_branch, out_in_delay_slot;
    logic [PTR_W:0]   count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [4:0]  exc;
        logic        br;
        logic        ds;
    } ent_t;

    ent_t q[$];
    logic lpb;
    int   checks, errors;

    id_decode_queue #(.PTR_W(PTR_W), .EXC_W(EXC_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_next_pc(in_next_pc), .in_exc_code(in_exc_code), .in_exc_addr(in_exc_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_next_pc(out_next_pc), .out_epc(out_epc), .out_badvaddr(out_badvaddr),
        .out_exc_code(out_exc_code), .out_is_branch(out_is_branch),
        .out_in_delay_slot(out_in_delay_slot), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic tb_isbr(input logic [31:0] w);
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        op = w[31:26];
        rt = w[20:16];
        fn = w[5:0];
        return (op >= 6'd2 && op <= 6'd7) || (op == 6'd1 && rt <= 5'd1) ||
               (op == 6'd0 && (fn == 6'd8 || fn == 6'd9));
    endfunction

    function automatic ent_t head();
        ent_t a;
        a.instr = out_instr;     a.npc = out_next_pc;  a.epc = out_epc;
        a.bad   = out_badvaddr;  a.exc = out_exc_code;
        a.br    = out_is_branch; a.ds  = out_in_delay_slot;
        return a;
    endfunction

    // Drives one clock of stimulus and advances the reference model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                         input logic [4:0] ec, input logic [31:0] ea,
                         input logic ordy, input logic clr);
        ent_t e;
        logic do_push, do_pop;
        in_valid = v; in_instr = ins; in_next_pc = npc; in_exc_code = ec;
        in_exc_addr = ea; out_ready = ordy; clear = clr;
        do_push = v && (q.size() < DEPTH) && !clr && !rst;
        do_pop  = (q.size() != 0) && ordy && !clr && !rst;
        if (rst || clr) begin
            q.delete();
            lpb = 1'b0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.npc = npc; e.exc = ec; e.ds = lpb;
                if (ec != 5'd0) begin
                    e.instr = 32'h0; e.epc = ea; e.bad = ea; e.br = 1'b0;
                end else begin
                    e.instr = ins; e.br = tb_isbr(ins); e.bad = 32'h0;
                    e.epc = npc - (lpb ? 32'd8 : 32'd4);
                end
                lpb = e.br;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        lpb = 1'b0;
        cycle(0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_fill_drain();
        ent_t a, x;
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h2001_0000 | i, 32'h1000 + 4*i, 5'd0, 32'h0, 0, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        cycle(1, 32'h2001_00FF, 32'h1010, 5'd0, 32'h0, 0, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            a = head(); x = q[0];
            checks++; if (a !== x) begin errors++; $display("FAIL drain_head%0d got=%h exp=%h", i, a, x); end
            checks++; if (a.instr !== (32'h2001_0000 | i)) begin errors++; $display("FAIL drain_order%0d got=%h exp=%h", i, a.instr, 32'h2001_0000 | i); end
            cycle(0, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0);
        end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, out_valid); end
    endtask

    task automatic test_delay_slot();
        ent_t a, x;
        cycle(1, 32'h1022_0003, 32'h104, 5'd0, 32'h0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwft_latency got=%b exp=1", out_valid); end
        cycle(1, 32'h2442_0001, 32'h108, 5'd0, 32'h0, 0, 0);
        cycle(1, 32'h0000_0000, 32'h10C, 5'd0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            a = head(); x = q[0];
            checks++; if (a !== x) begin errors++; $display("FAIL ds_head%0d got=%h exp=%h", i, a, x); end
            if (i == 0) begin
                checks++; if (a.br !== 1'b1 || a.epc !== 32'h100) begin errors++; $display("FAIL beq_br_epc got=%b/%h exp=1/00000100", a.br, a.epc); end
            end else if (i == 1) begin
                checks++; if (a.ds !== 1'b1 || a.epc !== 32'h100) begin errors++; $display("FAIL slot_ds_epc got=%b/%h exp=1/00000100", a.ds, a.epc); end
            end else begin
                checks++; if (a.ds !== 1'b0 || a.epc !== 32'h108) begin errors++; $display("FAIL after_slot got=%b/%h exp=0/00000108", a.ds, a.epc); end
            end
            cycle(0, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0);
        end
    endtask

    task automatic test_exception();
        ent_t a, x;
        cycle(1, 32'h1000_0001, 32'h204, EC_ADEL, 32'h8000_0003, 0, 0);
        a = head(); x = q[0];
        checks++; if (a !== x) begin errors++; $display("FAIL exc_head got=%h exp=%h", a, x); end
        checks++;
        if (out_exc_code !== EC_ADEL || out_epc !== 32'h8000_0003 || out_badvaddr !== 32'h8000_0003 ||
            out_instr !== 32'h0 || out_is_branch !== 1'b0) begin
            errors++;
            $display("FAIL exc_fields got=%0d/%h/%h/%h/%b exp=4/80000003/80000003/00000000/0",
                     out_exc_code, out_epc, out_badvaddr, out_instr, out_is_branch);
        end
        cycle(0, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0);
        // The exception entry must not open a delay slot even though its raw word is a BEQ.
        cycle(1, 32'h2442_0001, 32'h208, 5'd0, 32'h0, 0, 0);
        checks++; if (out_in_delay_slot !== 1'b0 || out_epc !== 32'h204) begin errors++; $display("FAIL exc_no_slot got=%b/%h exp=0/00000204", out_in_delay_slot, out_epc); end
        cycle(0, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0);
    endtask

    task automatic test_clear();
        ent_t a, x;
        cycle(1, 32'h0022_1820, 32'h300, 5'd0, 32'h0, 0, 0);
        cycle(1, 32'h03E0_0008, 32'h304, 5'd0, 32'h0, 0, 0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL clr_pre_count got=%0d exp=2", count); end
        cycle(1, 32'h2442_0001, 32'h308, 5'd0, 32'h0, 1, 1);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_empty got=%0d/%b exp=0/0", count, out_valid); end
        cycle(1, 32'h2442_0001, 32'h30C, 5'd0, 32'h0, 0, 0);
        a = head(); x = q[0];
        checks++; if (a !== x) begin errors++; $display("FAIL clr_next_head got=%h exp=%h", a, x); end
        checks++; if (out_in_delay_slot !== 1'b0 || out_epc !== 32'h308) begin errors++; $display("FAIL clr_ds got=%b/%h exp=0/00000308", out_in_delay_slot, out_epc); end
        cycle(0, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0);
    endtask

    task automatic test_back_to_back();
        ent_t a, x;
        logic [31:0] words [10];
        words = '{32'h1422_0001, 32'h0000_0000, 32'h0421_0002, 32'h0442_0002, 32'h0040_F809,
                  32'h2442_0001, 32'h0800_0010, 32'h1840_0001, 32'h0000_0020, 32'h1C40_0001};
        cycle(1, words[0], 32'h404, 5'd0, 32'h0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            a = head(); x = q[0];
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=1", i, count); end
            checks++; if (a !== x) begin errors++; $display("FAIL b2b_head%0d got=%h exp=%h", i, a, x); end
            cycle(1, words[i % 10], 32'h404 + 4*i, 5'd0, 32'h0, 1, 0);
        end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_end_count got=%0d exp=1", count); end
        rst = 1'b1;
        cycle(1, words[3], 32'h500, 5'd0, 32'h0, 1, 0);
        rst = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst got=%0d/%b exp=0/0", count, out_valid); end
    endtask

    initial begin
        checks = 0; errors = 0; lpb = 1'b0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_next_pc = '0; in_exc_code = '0; in_exc_addr = '0;
        test_reset();
        test_fill_drain();
        test_delay_slot();
        test_exception();
        test_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
